// File: rtl/direct_mapped_dcache_if.sv
// Core-side and backing-memory-side signals of the direct-mapped data cache.
// The slave modport is the cache's view. The master modport is the core plus memory.
interface direct_mapped_dcache_if;
  logic [29:0] cpu_addr;
  logic        cpu_re;
  logic [3:0]  cpu_we;
  logic [31:0] cpu_din;
  logic [31:0] cpu_dout;
  logic        stall;
  logic        mem_req_valid;
  logic        mem_req_ready;
  logic        mem_req_rw;
  logic [29:0] mem_req_addr;
  logic [31:0] mem_req_data;
  logic [3:0]  mem_req_mask;
  logic        mem_resp_valid;
  logic [31:0] mem_resp_data;

  modport slave (
    input  cpu_addr, cpu_re, cpu_we, cpu_din,
    output cpu_dout, stall,
    output mem_req_valid, mem_req_rw, mem_req_addr, mem_req_data, mem_req_mask,
    input  mem_req_ready, mem_resp_valid, mem_resp_data
  );

  modport master (
    output cpu_addr, cpu_re, cpu_we, cpu_din,
    input  cpu_dout, stall,
    input  mem_req_valid, mem_req_rw, mem_req_addr, mem_req_data, mem_req_mask,
    output mem_req_ready, mem_resp_valid, mem_resp_data
  );
endinterface

// File: rtl/direct_mapped_dcache.sv
// Direct-mapped, one-word-per-line, write-through / no-write-allocate data cache.
// Every output is registered. A single memory transaction is in flight at a time.
module direct_mapped_dcache #(
  parameter int LINES = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  direct_mapped_dcache_if.slave  bus
);
  localparam int IDX = $clog2(LINES);
  localparam int TW  = 30 - IDX;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    FILL_REQ  = 2'd1,
    FILL_WAIT = 2'd2,
    WRITE_REQ = 2'd3
  } state_t;

  state_t           r_state;
  logic [31:0]      r_data [LINES];
  logic [TW-1:0]    r_tag  [LINES];
  logic [LINES-1:0] r_valid;
  logic [31:0]      r_dout;
  logic             r_stall;
  logic             r_req_valid;
  logic             r_req_rw;
  logic [29:0]      r_req_addr;
  logic [31:0]      r_req_data;
  logic [3:0]       r_req_mask;

  logic [IDX-1:0]   w_idx;
  logic [TW-1:0]    w_tag;
  logic [IDX-1:0]   w_fill_idx;
  logic             w_hit;
  logic             w_acc_wr;
  logic             w_acc_rd;
  logic             w_fill_done;
  logic [31:0]      w_merged;

  assign w_idx       = bus.cpu_addr[IDX-1:0];
  assign w_tag       = bus.cpu_addr[29:IDX];
  assign w_fill_idx  = r_req_addr[IDX-1:0];
  assign w_hit       = r_valid[w_idx] && (r_tag[w_idx] == w_tag);
  // A write enable wins over a simultaneous read request.
  assign w_acc_wr    = (r_state == IDLE) && (bus.cpu_we != 4'b0000);
  assign w_acc_rd    = (r_state == IDLE) && (bus.cpu_we == 4'b0000) && bus.cpu_re;
  assign w_fill_done = (r_state == FILL_WAIT) && bus.mem_resp_valid;

  // Store-hit word: enabled byte lanes come from the core, others from the line.
  always_comb begin
    w_merged = r_data[w_idx];
    for (int b = 0; b < 4; b++) begin
      if (bus.cpu_we[b]) begin
        w_merged[8*b +: 8] = bus.cpu_din[8*b +: 8];
      end else begin
        w_merged[8*b +: 8] = r_data[w_idx][8*b +: 8];
      end
    end
  end

  // Data and tag arrays: written by fills and by store hits, never while in reset.
  always_ff @(posedge clk) begin
    if (!reset) begin
      if (w_fill_done) begin
        r_data[w_fill_idx] <= bus.mem_resp_data;
        r_tag[w_fill_idx]  <= r_req_addr[29:IDX];
      end else if (w_acc_wr && w_hit) begin
        r_data[w_idx] <= w_merged;
      end
    end
  end

  // Controller FSM with registered stall, read data and memory request fields.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= IDLE;
      r_valid     <= '0;
      r_dout      <= 32'h0000_0000;
      r_stall     <= 1'b0;
      r_req_valid <= 1'b0;
      r_req_rw    <= 1'b0;
      r_req_addr  <= 30'h0;
      r_req_data  <= 32'h0000_0000;
      r_req_mask  <= 4'b0000;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_acc_wr) begin
            r_state     <= WRITE_REQ;
            r_stall     <= 1'b1;
            r_req_valid <= 1'b1;
            r_req_rw    <= 1'b1;
            r_req_addr  <= bus.cpu_addr;
            r_req_data  <= bus.cpu_din;
            r_req_mask  <= bus.cpu_we;
          end else if (w_acc_rd && w_hit) begin
            r_dout <= r_data[w_idx];
          end else if (w_acc_rd) begin
            r_state     <= FILL_REQ;
            r_stall     <= 1'b1;
            r_req_valid <= 1'b1;
            r_req_rw    <= 1'b0;
            r_req_addr  <= bus.cpu_addr;
            r_req_mask  <= 4'b0000;
          end
        end
        FILL_REQ: begin
          if (bus.mem_req_ready) begin
            r_state     <= FILL_WAIT;
            r_req_valid <= 1'b0;
          end
        end
        FILL_WAIT: begin
          if (bus.mem_resp_valid) begin
            r_state             <= IDLE;
            r_stall             <= 1'b0;
            r_valid[w_fill_idx] <= 1'b1;
            r_dout              <= bus.mem_resp_data;
          end
        end
        WRITE_REQ: begin
          if (bus.mem_req_ready) begin
            r_state     <= IDLE;
            r_stall     <= 1'b0;
            r_req_valid <= 1'b0;
          end
        end
        default: begin
          r_state     <= IDLE;
          r_stall     <= 1'b0;
          r_req_valid <= 1'b0;
        end
      endcase
    end
  end

  assign bus.cpu_dout      = r_dout;
  assign bus.stall         = r_stall;
  assign bus.mem_req_valid = r_req_valid;
  assign bus.mem_req_rw    = r_req_rw;
  assign bus.mem_req_addr  = r_req_addr;
  assign bus.mem_req_data  = r_req_data;
  assign bus.mem_req_mask  = r_req_mask;
endmodule
